// File: rtl/serial_add_defs_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_defs
// Shared definitions for the bit-serial add/subtract controller:
//   - controller state encoding
//   - default operand width and bit-counter width
//   - helper to check that a counter width can index every operand bit
// -----------------------------------------------------------------------------
package serial_add_defs;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CW    = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // True when a CW-bit counter can reach WIDTH-1 without wrapping.
  function automatic bit cw_fits(input int width, input int cw);
    return ((64'd1 << cw) > width);
  endfunction

endpackage

// File: rtl/fadder.sv
// -----------------------------------------------------------------------------
// fadder
// Single-bit full adder; the one datapath cell shared across all bit slots
// of the serial controller.
//   a, b  : input  operand bits
//   cin   : input  carry in
//   s     : output sum bit
//   cout  : output carry out
// -----------------------------------------------------------------------------
module fadder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial add/subtract controller. One bit per clock, LSB first, through a
// single fadder; the carry lives in a flip-flop between bit slots. A result
// takes WIDTH+1 cycles from the accepting edge to the done pulse.
//
// Ports
//   clk    : input  rising-edge clock
//   rst    : input  synchronous active-high reset
//   start  : input  request, sampled only while ready
//   a, b   : input  WIDTH-bit operands, captured on the accepting edge
//   cin    : input  carry in for add (ignored for subtract)
//   sub    : input  0 = a+b+cin, 1 = a-b (a + ~b + 1)
//   ready  : output can accept start this cycle
//   busy   : output serial operation in progress
//   done   : output one-cycle result-valid pulse
//   sum    : output result, held until the next result load
//   cout   : output final carry (subtract: 1 = no borrow)
//   ovf    : output signed overflow
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; ready=1
// S_RUN  | one operand bit per clock through the fadder; busy=1
// S_DONE | one-cycle done pulse; ready=1, start here chains a new op
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = DEFAULT_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (!cw_fits(WIDTH, CW)) begin : g_cw_check
    $error("serial_add_ctrl: CW too small for WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_cout;
  logic             launch;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;

  fadder u_fadder (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at position 0.
  assign res_shift = {fa_s, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    launch  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready   = 1'b1;
        launch  = start;
        state_d = start ? S_RUN : S_IDLE;
      end

      S_RUN: begin
        busy    = 1'b1;
        res_d   = res_shift;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          sum_d   = res_shift;
          cout_d  = fa_cout;
          // carry_q is the carry into the MSB slot at this point.
          ovf_d   = carry_q ^ fa_cout;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        launch  = start;
        state_d = start ? S_RUN : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Subtract is a + ~b + 1: invert b and force the initial carry high.
    if (launch) begin
      opa_d   = a;
      opb_d   = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(W), .CW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: integer arithmetic on the operand values.
  // Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    int ux, uy, sx, sy, ur, sr;
    logic [W-1:0] rs;
    logic rc, ro;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      rc = (ux >= uy);
    end else begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      rc = (ur >= (1 << W));
    end
    rs = ur[W-1:0];
    ro = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
    return {ro, rc, rs};
  endfunction

  // Launches one op from a negedge where the DUT is ready, scrambles the
  // inputs after the accepting edge, and waits (bounded) for done.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s,
                       output int n, output logic [W-1:0] rs,
                       output logic rc, output logic ro, output logic run_ok);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    n = 0;
    run_ok = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (!busy || ready) run_ok = 1'b0;
    end
    rs = sum; rc = cout; ro = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if ({ovf, cout, sum} !== '0) begin fails++;
      $display("FAIL reset_outputs: got ovf=%b cout=%b sum=%h want 0", ovf, cout, sum); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] xs [6] = '{8'h5A, 8'hFF, 8'h00, 8'h10, 8'h80, 8'h7F};
    logic [W-1:0] ys [6] = '{8'h3C, 8'h01, 8'h00, 8'h20, 8'h01, 8'h7F};
    logic         cs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         ss [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] es [6] = '{8'h96, 8'h00, 8'h01, 8'hF0, 8'h7F, 8'hFF};
    logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         eo [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int n;
    logic [W-1:0] rs;
    logic rc, ro, ok;
    for (int i = 0; i < 6; i++) begin
      do_op(xs[i], ys[i], cs[i], ss[i], n, rs, rc, ro, ok);
      tests++; if (n !== W + 1) begin fails++; $display("FAIL dir%0d_latency: got %0d want %0d", i, n, W + 1); end
      tests++; if (!ok) begin fails++; $display("FAIL dir%0d_busy: busy/ready wrong during run", i); end
      tests++; if ({ro, rc, rs} !== {eo[i], ec[i], es[i]}) begin fails++;
        $display("FAIL dir%0d_result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                 i, ro, rc, rs, eo[i], ec[i], es[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int n, gap;
    logic [W-1:0] x, y, rs, held;
    logic ci, s, rc, ro, ok;
    logic [W+1:0] exp;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom); ci = 1'($urandom); s = 1'($urandom);
      exp = model(x, y, ci, s);
      do_op(x, y, ci, s, n, rs, rc, ro, ok);
      tests++; if (n !== W + 1 || !ok) begin fails++;
        $display("FAIL rnd%0d_timing: got latency %0d busy_ok=%b want %0d/1", i, n, ok, W + 1); end
      tests++; if ({ro, rc, rs} !== exp) begin fails++;
        $display("FAIL rnd%0d_result: a=%h b=%h cin=%b sub=%b got %b_%b_%h want %b_%b_%h",
                 i, x, y, ci, s, ro, rc, rs, exp[W+1], exp[W], exp[W-1:0]); end
      held = sum;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        tests++; if (sum !== held || done !== 1'b0 || ready !== 1'b1) begin fails++;
          $display("FAIL rnd%0d_hold: got sum=%h done=%b ready=%b want sum=%h done=0 ready=1",
                   i, sum, done, ready, held); end
      end
      // gap == 0 launches straight from DONE.
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dones = 0, first_k = 0;
    logic [W-1:0] rs = '0;
    a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1; end
      if (k == 4) start = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) begin first_k = k; rs = sum; end
      end
    end
    tests++; if (dones !== 1) begin fails++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    tests++; if (first_k !== W + 1) begin fails++; $display("FAIL ignore_latency: got %0d want %0d", first_k, W + 1); end
    tests++; if (rs !== 8'h96) begin fails++; $display("FAIL ignore_result: got %h want 96", rs); end
  endtask

  task automatic test_back_to_back();
    int k1 = 0, k2 = 0;
    logic [W-1:0] s1 = '0, s2 = '0;
    logic nogap = 1'b0;
    logic [W+1:0] e1, e2;
    e1 = model(8'hC3, 8'h4E, 1'b1, 1'b0);
    e2 = model(8'h10, 8'h20, 1'b0, 1'b1);
    a = 8'hC3; b = 8'h4E; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k1 != 0 && k == k1 + 1) begin
        nogap = busy && !ready;
        start = 1'b0;
      end
      if (done) begin
        if (k1 == 0) begin
          k1 = k; s1 = sum;
          a = 8'h10; b = 8'h20; cin = 1'b1; sub = 1'b1;
        end else if (k2 == 0) begin
          k2 = k; s2 = sum;
        end
      end
    end
    start = 1'b0;
    tests++; if (s1 !== e1[W-1:0]) begin fails++; $display("FAIL b2b_first: got %h want %h", s1, e1[W-1:0]); end
    tests++; if (!nogap) begin fails++; $display("FAIL b2b_nogap: got busy=0 after DONE want busy=1"); end
    tests++; if (k2 - k1 !== W + 1) begin fails++; $display("FAIL b2b_spacing: got %0d want %0d", k2 - k1, W + 1); end
    tests++; if (s2 !== e2[W-1:0]) begin fails++; $display("FAIL b2b_second: got %h want %h", s2, e2[W-1:0]); end
  endtask

  task automatic test_reset_mid_run();
    int n, dones = 0;
    logic [W-1:0] rs;
    logic rc, ro, ok;
    // Leave a nonzero result behind so the clear is observable.
    do_op(8'h80, 8'h01, 1'b0, 1'b1, n, rs, rc, ro, ok);
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL midrst_state: got ready=%b busy=%b done=%b want 1/0/0", ready, busy, done); end
    tests++; if ({ovf, cout, sum} !== '0) begin fails++;
      $display("FAIL midrst_outputs: got ovf=%b cout=%b sum=%h want 0", ovf, cout, sum); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests++; if (dones !== 0) begin fails++; $display("FAIL midrst_nodone: got %0d done pulses want 0", dones); end
    do_op(8'h00, 8'h00, 1'b1, 1'b0, n, rs, rc, ro, ok);
    tests++; if (n !== W + 1 || {ro, rc, rs} !== {1'b0, 1'b0, 8'h01}) begin fails++;
      $display("FAIL midrst_fresh: got latency %0d ovf=%b cout=%b sum=%h want %0d 0 0 01", n, ro, rc, rs, W + 1); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
